// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU-to-Wishbone bridge.
//   size_e  : access size as carried on req_size_i
//   state_e : bridge FSM states
//   misaligned() : alignment/legality check for a request
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    // Size 11 is treated as a misaligned access so it takes the same error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the bridge.
//   rd_word     : word read from the bus
//   offset      : byte offset (addr[1:0]) of the access
//   size        : access size (size_e encoding)
//   is_unsigned : zero-extend instead of sign-extend loads
//   wdata       : store data, LSB-aligned
//   load_data   : extracted and extended load result
//   merged      : rd_word with the addressed lane replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rd_word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: load_data = rd_word;
        endcase

        merged = rd_word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_wb_bridge.sv
// Single-outstanding bridge from a core load/store port to a classic
// Wishbone memory slave. Sub-word stores are done as read-modify-write with a
// one-cycle idle gap so the slave's lingering registered ack is never mistaken
// for the write ack.
//   req_*  : core request (valid/ready handshake)
//   rsp_*  : one-cycle response pulse, no back-pressure
//   wb_*   : Wishbone master side, all outputs registered
module lsu_wb_bridge
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,   // only 32 supported
    parameter int WB_ADR_WIDTH = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [31:0]             req_addr_i,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state;
    logic [1:0]         r_off;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_we;
    logic [31:0]        r_wdata;   // store data, then the merged word after RD
    logic [CNT_W-1:0]   cnt;

    logic [31:0]        load_data;
    logic [31:0]        merged;
    logic               timed_out;

    // Upper address bits beyond the slave's word address are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:WB_ADR_WIDTH+2];

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    lsu_lane_align u_align (
        .rd_word     (wb_dat_i),
        .offset      (r_off),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            r_off       <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        r_off       <= req_addr_i[1:0];
                        r_size      <= req_size_i;
                        r_unsigned  <= req_unsigned_i;
                        r_we        <= req_we_i;
                        r_wdata     <= req_wdata_i;
                        wb_adr_o    <= req_addr_i[WB_ADR_WIDTH+1:2];
                        cnt         <= '0;
                        if (misaligned(req_size_i, req_addr_i[1:0])) begin
                            state       <= ST_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else if (req_we_i && req_size_i == SZ_WORD) begin
                            // Full-word store needs no read.
                            state    <= ST_WR;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_dat_o <= req_wdata_i;
                        end else begin
                            state    <= ST_RD;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        cnt      <= '0;
                        if (r_we) begin
                            r_wdata <= merged;
                            state   <= ST_GAP;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= load_data;
                            state       <= ST_RSP;
                        end
                    end else if (timed_out) begin
                        // Abandon the access; a pending write is dropped.
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        cnt         <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state       <= ST_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Idle cycle lets the read's lingering ack expire before WR.
                ST_GAP: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= 1'b1;
                    wb_dat_o <= r_wdata;
                    cnt      <= '0;
                    state    <= ST_WR;
                end

                ST_WR: begin
                    if (wb_ack_i || timed_out) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_we_o     <= 1'b0;
                        wb_dat_o    <= '0;
                        cnt         <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ~wb_ack_i;
                        state       <= ST_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RSP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb_bridge.sv
// Bench for lsu_wb_bridge: a registered-ack memory slave, a transaction-level
// reference model (expected latency, bus activity, data and memory contents),
// directed cases for the called-out scenarios and a randomized sweep.
module tb_lsu_wb_bridge;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        ack;

    logic        ack_en;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          wr_cnt = 0;
    int          n_chk  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    lsu_wb_bridge #(.DATA_WIDTH(32), .WB_ADR_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_we_o        (wb_we_o),
        .wb_stb_o       (wb_stb_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (ack)
    );

    // Slave: ack is stb registered, so it lingers one cycle after stb drops.
    assign wb_dat_i = (wb_stb_o && !wb_we_o) ? mem[wb_adr_o] : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) ack <= 1'b0;
        else     ack <= wb_cyc_o & wb_stb_o & ack_en;
    end

    always @(posedge clk) begin
        if (ack && wb_stb_o && wb_we_o) begin
            mem[wb_adr_o] <= wb_dat_o;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request (caller is at a negedge) and check it against the model.
    task automatic run_req(input string tag, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        logic [7:0]  idx;
        logic [31:0] old, mask, e_rdata, e_word, g_rdata;
        logic        mis, e_err, g_err, g_cyc;
        int sh, e_lat, e_stb, e_gap, e_wr;
        int lat, stbc, first, last, bad, wr0, waitc, gap;

        // Reference model
        idx  = addr[9:2];
        old  = ref_mem[idx];
        mis  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
        sh   = (size == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask = (size == 2'b00) ? 32'hFF : ((size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF);
        e_rdata = 32'h0; e_word = old; e_err = 1'b0; e_gap = 0; e_wr = 0;
        if (mis) begin
            e_err = 1'b1; e_lat = 1; e_stb = 0;
        end else if (!ack_en) begin
            e_err = 1'b1; e_lat = TIMEOUT + 1; e_stb = TIMEOUT;
        end else if (!we) begin
            e_lat = 3; e_stb = 2;
            e_rdata = (old >> sh) & mask;
            if (!uns && size == 2'b00 && e_rdata[7])  e_rdata = e_rdata | 32'hFFFF_FF00;
            if (!uns && size == 2'b01 && e_rdata[15]) e_rdata = e_rdata | 32'hFFFF_0000;
        end else if (size == 2'b10) begin
            e_lat = 3; e_stb = 2; e_wr = 1; e_word = wdata;
        end else begin
            e_lat = 6; e_stb = 4; e_gap = 1; e_wr = 1;
            e_word = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        end
        ref_mem[idx] = e_word;

        waitc = 0;
        while (!req_ready_o && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready_o) begin
            chk({tag, ".ready"}, 32'(req_ready_o), 32'h1);
            return;
        end

        wr0 = wr_cnt;
        req_valid_i    = 1'b1;
        req_addr_i     = addr;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;

        lat = 0; stbc = 0; first = -1; last = -1; bad = 0;
        g_err = 1'b0; g_cyc = 1'b0; g_rdata = 32'h0;
        for (int k = 1; k <= TIMEOUT + 20 && lat == 0; k++) begin
            @(negedge clk);
            if (wb_stb_o) begin
                stbc++;
                if (first < 0) first = k;
                last = k;
            end
            if (rsp_valid_o) begin
                lat = k; g_err = rsp_err_o; g_rdata = rsp_rdata_o; g_cyc = wb_cyc_o;
            end else if (rsp_rdata_o != 32'h0 || rsp_err_o) begin
                bad++;
            end
        end
        gap = (stbc > 0) ? (last - first + 1 - stbc) : 0;

        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".err"}, 32'(g_err), 32'(e_err));
        chk({tag, ".rdata"}, g_rdata, e_rdata);
        chk({tag, ".stb_cycles"}, 32'(stbc), 32'(e_stb));
        chk({tag, ".gap"}, 32'(gap), 32'(e_gap));
        chk({tag, ".cyc_at_rsp"}, 32'(g_cyc), 32'h0);
        chk({tag, ".idle_rsp_quiet"}, 32'(bad), 32'h0);
        @(negedge clk);
        chk({tag, ".rsp_one_cycle"}, {31'h0, rsp_valid_o} | rsp_rdata_o, 32'h0);
        chk({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(e_wr));
        chk({tag, ".mem"}, mem[idx], e_word);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w, u;
        logic [1:0]  s;
        int          rv, wr0;

        rst = 1'b1; ack_en = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
        req_size_i = '0; req_unsigned_i = 1'b0; req_wdata_i = '0;
        for (int i = 0; i < 256; i++) begin
            a = $urandom;
            mem[i]     <= a;
            ref_mem[i] = a;
        end
        mem[8'h04] <= 32'h80FF_1234; ref_mem[8'h04] = 32'h80FF_1234;
        mem[8'h00] <= 32'h1122_3344; ref_mem[8'h00] = 32'h1122_3344;

        @(negedge clk); @(negedge clk);
        chk("reset.bus_ctl", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        chk("reset.adr_dat", {24'h0, wb_adr_o} | wb_dat_o, 32'h0);
        chk("reset.rsp", {30'h0, rsp_valid_o, rsp_err_o} | rsp_rdata_o, 32'h0);
        chk("reset.ready", 32'(req_ready_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_req("lb_signed",  32'h0000_0013, 1'b0, 2'b00, 1'b0, 32'h0);
        run_req("sb",         32'h0000_0001, 1'b1, 2'b00, 1'b0, 32'h0000_00AB);
        run_req("sw",         32'h0000_0020, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF);
        run_req("lw_b2b",     32'h0000_0020, 1'b0, 2'b10, 1'b0, 32'h0);
        run_req("lh_misalgn", 32'h0000_0003, 1'b0, 2'b01, 1'b0, 32'h0);
        run_req("lhu_hi",     32'h0000_0012, 1'b0, 2'b01, 1'b1, 32'h0);
        ack_en = 1'b0;
        run_req("lw_timeout", 32'h0000_0044, 1'b0, 2'b10, 1'b0, 32'h0);
        run_req("sh_timeout", 32'h0000_0046, 1'b1, 2'b01, 1'b0, 32'h5555);
        ack_en = 1'b1;

        // Reset while a word store is in its WR phase.
        wr0 = wr_cnt;
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0040; req_we_i = 1'b1;
        req_size_i = 2'b10; req_unsigned_i = 1'b0; req_wdata_i = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_wr.in_wr", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h7);
        rst = 1'b1;
        #1;
        chk("rst_wr.bus_ctl", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        chk("rst_wr.adr_dat", {24'h0, wb_adr_o} | wb_dat_o, 32'h0);
        chk("rst_wr.ready", 32'(req_ready_o), 32'h0);
        rv = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid_o) rv++;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid_o) rv++;
        end
        chk("rst_wr.no_rsp", 32'(rv), 32'h0);
        chk("rst_wr.no_write", 32'(wr_cnt - wr0), 32'h0);
        run_req("lw_after_rst", 32'h0000_0040, 1'b0, 2'b10, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            ack_en = ($urandom_range(0, 7) != 0);
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                if (s == 2'b10) a[1:0] = 2'b00;
            end
            run_req($sformatf("rand%0d", i), a, w, s, u, $urandom);
        end
        ack_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_wb_bridge.md
LSU_WB_BRIDGE -- requirements
Module: lsu_wb_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width; only 32 is supported.
REQ-002 SHALL have parameter WB_ADR_WIDTH, default 8, word-address width driven to the memory slave.
REQ-003 SHALL have parameter TIMEOUT, default 16, bus cycles to wait for ack before error.
REQ-004 SHALL have one clock, clk, and reset, rst; rst is asynchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  bridge accepts request
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend load
- req_wdata_i  in  32  store data, LSB-aligned
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  extended load data
- rsp_err_o  out  1  misaligned/illegal/timeout
- wb_adr_o  out  WB_ADR_WIDTH  word address
- wb_dat_o  out  32  write data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_dat_i  in  32  read data, valid while stb & !we
- wb_ack_i  in  1  slave ack, registered one cycle after stb

Function
REQ-006 SHALL implement FSM IDLE, RD, GAP, WR, RSP; req_ready_o=1 only in IDLE; request latched on req_valid_i & req_ready_o.
REQ-007 SHALL flag misaligned requests (half with addr[0]=1, word with addr[1:0]!=0, size 11) -> RSP with rsp_err_o=1 next cycle, no bus cycle.
REQ-008 SHALL drive wb_adr_o = addr[WB_ADR_WIDTH+1:2]; higher address bits ignored.
REQ-009 SHALL route loads and byte/half stores IDLE->RD and word stores IDLE->WR.
REQ-010 SHALL, in RD, drive cyc=stb=1, we=0; on wb_ack_i capture wb_dat_i; a load goes to RSP, a sub-word store merges and goes to GAP.
REQ-011 SHALL hold cyc=stb=0 for exactly one cycle in GAP, then go to WR.
REQ-012 SHALL, in WR, drive cyc=stb=we=1 and wb_dat_o = merged word; on wb_ack_i go to RSP.
REQ-013 SHALL ignore wb_ack_i in every state except RD and WR, since the slave's registered ack lingers one cycle after stb drops.
REQ-014 SHALL count cycles in RD/WR; on reaching TIMEOUT without ack, drop cyc/stb, skip any pending write, and go to RSP with rsp_err_o=1.
REQ-015 SHALL assert rsp_valid_o for exactly one cycle in RSP, then return to IDLE; responses have no back-pressure.
REQ-016 SHALL extract loads by lane (byte: addr[1:0]; half: addr[1]) and sign- or zero-extend per req_unsigned_i; rsp_rdata_o=0 for stores, errors, and outside RSP.
REQ-017 SHALL merge stores by replacing only the addressed byte/half lane of the read word with req_wdata_i low bits.
REQ-018 SHALL drive all wb_* outputs from registers or state only, with no combinational path from req_* or wb_ack_i; wb_dat_o=0 outside WR.
REQ-019 SHALL meet these latencies from accept cycle A: word load/store rsp at A+3; sub-word store at A+6; misaligned at A+1.

Reset
REQ-020 SHALL, while rst is high, force state IDLE, all wb_* outputs 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, counters 0, and req_ready_o=0.
REQ-021 SHALL abandon any in-flight operation on rst mid-cycle and produce no response.

Structure
REQ-022 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings in shared package lsu_pkg.
REQ-023 SHALL implement lane extraction/extension and store merge in one combinational sub-module, lsu_lane_align.

Verification
REQ-024 SHALL test a signed byte load: memory word 0x80FF_1234 at addr 0x10, req lb addr 0x13 -> rsp_rdata_o=0xFFFF_FF80 at A+3, no write.
REQ-025 SHALL test a byte store: memory word 0x1122_3344, sb 0xAB to addr 0x01 -> read then one GAP cycle then write 0x1122_AB44, rsp at A+6.
REQ-026 SHALL test a word store then load back to back: sw 0xDEAD_BEEF addr 0x20, then lw addr 0x20 -> 0xDEAD_BEEF, and the stale ack does not complete the second request early.
REQ-027 SHALL test a misaligned access: lh addr 0x03 -> rsp_err_o=1 at A+1, wb_cyc_o never asserted.
REQ-028 SHALL test a timeout: slave ack tied 0, lw -> stb held 16 cycles, then rsp_err_o=1 with cyc dropped.
REQ-029 SHALL test reset mid-operation: rst asserted during WR -> wb outputs 0 immediately, no rsp_valid_o, bridge accepts a new request after release.
